// File: rtl/ext_mem_host_if.sv
// ext_mem_host_if: command, load stream, dump stream and RAM port
// bundle between the bring-up host and one GPU BlockRam.
interface ext_mem_host_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int WORD_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 17
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_dump;
  logic [ADDRESS_WIDTH-1:0] cmd_base;
  logic [COUNT_WIDTH-1:0]   cmd_count;

  logic                     in_valid;
  logic                     in_ready;
  logic [WORD_WIDTH-1:0]    in_data;

  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_WIDTH-1:0]    out_data;
  logic                     out_last;

  logic                     busy;
  logic                     done;

  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_write;
  logic [WORD_WIDTH-1:0]    mem_write_data;
  logic [WORD_WIDTH-1:0]    mem_read_data;

  modport master (
    input  cmd_valid, cmd_dump, cmd_base, cmd_count,
    output cmd_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data, out_last,
    input  out_ready,
    output busy, done,
    output mem_address, mem_write, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    output cmd_valid, cmd_dump, cmd_base, cmd_count,
    input  cmd_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  busy, done,
    input  mem_address, mem_write, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/ext_mem_host.sv
// ext_mem_host: loads a word stream into a BlockRam or dumps
// a range of it back out, through the RAM's external port.
module ext_mem_host #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int WORD_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 17
) (
  input  logic            clock,
  input  logic            reset_n,
  ext_mem_host_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DUMP_REQ,
    DUMP_RESP,
    DUMP_OUT
  } state_t;

  state_t                   state, state_nx;
  logic [ADDRESS_WIDTH-1:0] addr, addr_nx;
  logic [COUNT_WIDTH-1:0]   remaining, remaining_nx;
  logic [WORD_WIDTH-1:0]    out_data_q, out_data_nx;
  logic                     done_q, done_nx;
  logic                     last;

  assign last = (remaining == COUNT_WIDTH'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      addr       <= addr_nx;
      remaining  <= remaining_nx;
      out_data_q <= out_data_nx;
      done_q     <= done_nx;
    end
  end

  always_comb begin
    state_nx           = state;
    addr_nx            = addr;
    remaining_nx       = remaining;
    out_data_nx        = out_data_q;
    done_nx            = 1'b0;
    bus.cmd_ready      = 1'b0;
    bus.in_ready       = 1'b0;
    bus.out_valid      = 1'b0;
    bus.out_last       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_write_data = '0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_nx      = bus.cmd_base;
          remaining_nx = bus.cmd_count;
          if (bus.cmd_count == '0)
            done_nx = 1'b1;
          else if (bus.cmd_dump)
            state_nx = DUMP_REQ;
          else
            state_nx = LOAD;
        end
      end
      LOAD: begin
        bus.in_ready       = 1'b1;
        bus.mem_write      = bus.in_valid;
        bus.mem_write_data = bus.in_data;
        if (bus.in_valid) begin
          addr_nx      = addr + ADDRESS_WIDTH'(1);
          remaining_nx = remaining - COUNT_WIDTH'(1);
          if (last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      DUMP_REQ: state_nx = DUMP_RESP;
      DUMP_RESP: begin
        // RAM output is registered: the word for addr is valid now
        out_data_nx = bus.mem_read_data;
        state_nx    = DUMP_OUT;
      end
      DUMP_OUT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last;
        if (bus.out_ready) begin
          addr_nx      = addr + ADDRESS_WIDTH'(1);
          remaining_nx = remaining - COUNT_WIDTH'(1);
          if (last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = DUMP_REQ;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.mem_address = addr;
  assign bus.out_data    = out_data_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_ext_mem_host.sv
// tb_ext_mem_host: directed checks of load, dump, stall, wrap,
// zero-count and mid-command reset against a registered RAM model.
module tb_ext_mem_host;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  ext_mem_host_if #(16, 32, 17) bus ();

  ext_mem_host #(
    .ADDRESS_WIDTH(16),
    .WORD_WIDTH(32),
    .COUNT_WIDTH(17)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] ram [65536];

  always @(posedge clock) begin
    if (bus.mem_write) ram[bus.mem_address] <= bus.mem_write_data;
    bus.mem_read_data <= ram[bus.mem_address];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic dump, input logic [15:0] base,
                       input logic [16:0] count);
    @(posedge clock); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_dump  = dump;
    bus.cmd_base  = base;
    bus.cmd_count = count;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    bus.cmd_valid = 0; bus.cmd_dump = 0;
    bus.cmd_base = '0; bus.cmd_count = '0;
    bus.in_valid = 0; bus.in_data = '0;
    bus.out_ready = 0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_last,
         bus.busy, bus.done, bus.mem_write} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 1000000",
        {bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_last,
         bus.busy, bus.done, bus.mem_write});
    end
    checks++;
    if (bus.mem_address !== 16'h0 || bus.mem_write_data !== 32'h0 ||
        bus.out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_buses: got addr %h wdata %h odata %h expected zeros",
        bus.mem_address, bus.mem_write_data, bus.out_data);
    end
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
  endtask

  task automatic test_load;
    issue(1'b0, 16'h0010, 17'd4);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA0 + 32'(i);
      @(negedge clock);
      checks++;
      if (bus.mem_write !== 1'b1 || bus.in_ready !== 1'b1 ||
          bus.mem_address !== 16'h0010 + 16'(i) ||
          bus.mem_write_data !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL load_word%0d: got we %b rdy %b addr %h data %h expected 1 1 %h %h",
          i, bus.mem_write, bus.in_ready, bus.mem_address,
          bus.mem_write_data, 16'h0010 + 16'(i), 32'hA0 + 32'(i));
      end
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_done: got done %b busy %b cmd_ready %b expected 1 0 1",
        bus.done, bus.busy, bus.cmd_ready);
    end
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL load_done_pulse: got done %b expected 0", bus.done);
    end
  endtask

  task automatic test_dump;
    bus.out_ready = 1'b1;
    issue(1'b1, 16'h0010, 17'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (bus.mem_address !== 16'h0010 + 16'(i) || bus.out_valid !== 1'b0 ||
          bus.mem_write !== 1'b0) begin
        errors++;
        $display("FAIL dump_req%0d: got addr %h ov %b we %b expected %h 0 0",
          i, bus.mem_address, bus.out_valid, bus.mem_write, 16'h0010 + 16'(i));
      end
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA0 + 32'(i) ||
          bus.out_last !== (i == 3) || bus.mem_write !== 1'b0) begin
        errors++;
        $display("FAIL dump_out%0d: got ov %b data %h last %b we %b expected 1 %h %b 0",
          i, bus.out_valid, bus.out_data, bus.out_last, bus.mem_write,
          32'hA0 + 32'(i), (i == 3));
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dump_done: got done %b busy %b expected 1 0",
        bus.done, bus.busy);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall;
    bus.out_ready = 1'b0;
    issue(1'b1, 16'h0010, 17'd2);
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_dump  = 1'b0;
    bus.cmd_base  = 16'h0050;
    bus.cmd_count = 17'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA0 ||
          bus.mem_address !== 16'h0010 || bus.cmd_ready !== 1'b0 ||
          bus.mem_write !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got ov %b data %h addr %h crdy %b we %b expected 1 a0 0010 0 0",
          k, bus.out_valid, bus.out_data, bus.mem_address,
          bus.cmd_ready, bus.mem_write);
      end
      @(posedge clock); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.out_data !== 32'hA0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL stall_first: got data %h last %b expected a0 0",
        bus.out_data, bus.out_last);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (bus.mem_address !== 16'h0011) begin
      errors++;
      $display("FAIL stall_next_addr: got %h expected 0011", bus.mem_address);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA1 ||
        bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_second: got ov %b data %h last %b expected 1 a1 1",
        bus.out_valid, bus.out_data, bus.out_last);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got done %b busy %b expected 1 0",
        bus.done, bus.busy);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap;
    logic [15:0] ea;
    issue(1'b0, 16'hFFFE, 17'd4);
    for (int i = 0; i < 4; i++) begin
      ea = 16'hFFFE + 16'(i);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hB0 + 32'(i);
      @(negedge clock);
      checks++;
      if (bus.mem_write !== 1'b1 || bus.mem_address !== ea ||
          bus.mem_write_data !== 32'hB0 + 32'(i)) begin
        errors++;
        $display("FAIL wrap_word%0d: got we %b addr %h data %h expected 1 %h %h",
          i, bus.mem_write, bus.mem_address, bus.mem_write_data,
          ea, 32'hB0 + 32'(i));
      end
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clock);
          checks++;
          if (bus.mem_write !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL wrap_gap%0d_%0d: got we %b busy %b expected 0 1",
              i, g, bus.mem_write, bus.busy);
          end
          @(posedge clock); #1;
        end
      end
    end
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b1 || ram[16'h0001] !== 32'hB3 ||
        ram[16'hFFFF] !== 32'hB1) begin
      errors++;
      $display("FAIL wrap_done: got done %b ram1 %h ramffff %h expected 1 b3 b1",
        bus.done, ram[16'h0001], ram[16'hFFFF]);
    end
  endtask

  task automatic test_zero;
    for (int m = 0; m < 2; m++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      issue(m[0], 16'h0020, 17'd0);
      @(negedge clock);
      checks++;
      if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 ||
          bus.mem_write !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_mode%0d: got done %b crdy %b busy %b we %b ov %b expected 1 1 0 0 0",
          m, bus.done, bus.cmd_ready, bus.busy, bus.mem_write, bus.out_valid);
      end
      @(negedge clock);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_after%0d: got done %b busy %b expected 0 0",
          m, bus.done, bus.busy);
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 16'h0030, 17'd4);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hC0 + 32'(i);
      @(posedge clock); #1;
    end
    bus.in_data = 32'hC2;
    #2;
    checks++;
    if (bus.mem_write !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got we %b expected 1", bus.mem_write);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: got we %b busy %b crdy %b expected 0 0 1",
        bus.mem_write, bus.busy, bus.cmd_ready);
    end
    bus.in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock) reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_done%0d: got %b expected 0", k, bus.done);
      end
    end
    checks++;
    if (ram[16'h0030] !== 32'hC0 || ram[16'h0031] !== 32'hC1) begin
      errors++;
      $display("FAIL rst_kept: got %h %h expected c0 c1",
        ram[16'h0030], ram[16'h0031]);
    end
    issue(1'b0, 16'h0040, 17'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hD0;
    @(negedge clock);
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_address !== 16'h0040 ||
        bus.mem_write_data !== 32'hD0) begin
      errors++;
      $display("FAIL rst_new_load: got we %b addr %h data %h expected 1 0040 d0",
        bus.mem_write, bus.mem_address, bus.mem_write_data);
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_new_done: got done %b busy %b expected 1 0",
        bus.done, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_dump();
    test_stall();
    test_wrap();
    test_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
